// File: rtl/sfu_sched_pkg.sv
// ----------------------------------------------------------------------------
// sfu_sched_pkg: shared state encoding and CSR field layout for sfu_job_scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sfu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_STREAM    = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam int FUNC_MSB          = 31;
  localparam int FUNC_LSB          = 26;
  localparam int OPN_MSB           = 25;
  localparam int BUSY_WAIT_MAX_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter: round-robin arbiter, one-hot grant, pointer moves past winner on advance.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               idx;

  // Scan from the pointer, wrapping; first requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    ptr_d = ptr_q;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        idx_o      = IDX_W'(idx);
        any_o      = 1'b1;
        ptr_d      = IDX_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && any_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sfu_job_scheduler.sv
// ----------------------------------------------------------------------------
// sfu_job_scheduler: shares one SFU between NUM_REQ requesters; SFU_SCHED_PERF_CNT_EN adds perf counters.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sfu_job_scheduler
  import sfu_sched_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DataWidth       = 128,
  parameter int NUM_SOFTMAX_MAX = 128,
  parameter int PE_NUM          = 4,
  parameter int OPN_W           = $clog2(NUM_SOFTMAX_MAX / PE_NUM) + 1,
  parameter int BUSY_WAIT_MAX   = BUSY_WAIT_MAX_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
`ifdef SFU_SCHED_PERF_CNT_EN
  output logic [31:0]                  perf_busy_cycles_o,
  output logic [15:0]                  perf_jobs_o,
`endif
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [32*NUM_REQ-1:0]        req_csr_i,
  input  logic [NUM_REQ-1:0]           req_in_valid_i,
  output logic [NUM_REQ-1:0]           req_in_ready_o,
  input  logic [DataWidth*NUM_REQ-1:0] req_in_bits_i,
  output logic [NUM_REQ-1:0]           req_out_valid_o,
  input  logic [NUM_REQ-1:0]           req_out_ready_i,
  output logic [DataWidth-1:0]         req_out_bits_o,
  output logic [NUM_REQ-1:0]           req_done_o,
  output logic [NUM_REQ-1:0]           req_err_o,
  output logic [31:0]                  sfu_csr_o,
  output logic                         sfu_start_o,
  input  logic                         sfu_busy_i,
  output logic                         sfu_in_valid_o,
  input  logic                         sfu_in_ready_i,
  output logic [DataWidth-1:0]         sfu_in_bits_o,
  input  logic                         sfu_out_valid_i,
  output logic                         sfu_out_ready_o,
  input  logic [DataWidth-1:0]         sfu_out_bits_i
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OPN_LSB = OPN_MSB + 1 - OPN_W;
  localparam int MAX_OPS = NUM_SOFTMAX_MAX / PE_NUM;
  localparam int WAIT_W  = $clog2(BUSY_WAIT_MAX) + 1;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [31:0]        csr_q, csr_d;
  logic [OPN_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OPN_W-1:0]   out_cnt_q, out_cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               err_q, err_d;
  logic               bad_q, bad_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               arb_adv;

  logic [31:0]        win_csr;
  logic [OPN_W-1:0]   win_opn;
  logic               win_bad;
  logic [OPN_W-1:0]   opn;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .advance_i (arb_adv),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .any_o     (arb_any)
  );

  assign win_csr = req_csr_i[int'(arb_idx)*32 +: 32];
  assign win_opn = win_csr[OPN_MSB:OPN_LSB];
  assign win_bad = (win_opn == '0) || (win_opn > OPN_W'(MAX_OPS));
  assign opn     = csr_q[OPN_MSB:OPN_LSB];

  assign sfu_csr_o      = csr_q;
  assign sfu_in_bits_o  = req_in_bits_i[int'(gidx_q)*DataWidth +: DataWidth];
  assign req_out_bits_o = sfu_out_bits_i;

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gidx_d          = gidx_q;
    csr_d           = csr_q;
    in_cnt_d        = in_cnt_q;
    out_cnt_d       = out_cnt_q;
    wait_d          = wait_q;
    err_d           = err_q;
    bad_d           = bad_q;
    arb_adv         = 1'b0;
    req_ready_o     = '0;
    req_in_ready_o  = '0;
    req_out_valid_o = '0;
    req_done_o      = '0;
    req_err_o       = '0;
    sfu_start_o     = 1'b0;
    sfu_in_valid_o  = 1'b0;
    sfu_out_ready_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any && !rst_i) begin
          req_ready_o = arb_gnt;
          arb_adv     = 1'b1;
          gnt_d       = arb_gnt;
          gidx_d      = arb_idx;
          csr_d       = win_csr;
          bad_d       = win_bad;
          err_d       = win_bad;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wait_d = '0;
        // An illegal op count finishes without ever pulsing start.
        if (bad_q) begin
          state_d = S_DONE;
        end else begin
          sfu_start_o = 1'b1;
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (sfu_busy_i) begin
          state_d = S_STREAM;
        end else if (wait_q == WAIT_W'(BUSY_WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (in_cnt_q != opn) begin
          sfu_in_valid_o         = req_in_valid_i[gidx_q];
          req_in_ready_o[gidx_q] = sfu_in_ready_i;
          if (sfu_in_valid_o && sfu_in_ready_i) begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
        req_out_valid_o[gidx_q] = sfu_out_valid_i;
        sfu_out_ready_o         = req_out_ready_i[gidx_q];
        // The SFU cannot be back-pressured: every valid beat counts, unaccepted ones are lost.
        if (sfu_out_valid_i) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (!sfu_out_ready_o) begin
            err_d = 1'b1;
          end
          if (out_cnt_d == opn) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!sfu_busy_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        req_done_o = gnt_q;
        req_err_o  = err_q ? gnt_q : '0;
        in_cnt_d   = '0;
        out_cnt_d  = '0;
        wait_d     = '0;
        err_d      = 1'b0;
        bad_d      = 1'b0;
        csr_d      = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      csr_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      csr_q     <= csr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      bad_q     <= bad_d;
    end
  end

`ifdef SFU_SCHED_PERF_CNT_EN
  logic [31:0] perf_busy_q;
  logic [15:0] perf_jobs_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_busy_q <= '0;
      perf_jobs_q <= '0;
    end else begin
      if (state_q != S_IDLE && perf_busy_q != '1) begin
        perf_busy_q <= perf_busy_q + 1'b1;
      end
      if (state_q == S_DONE && perf_jobs_q != '1) begin
        perf_jobs_q <= perf_jobs_q + 1'b1;
      end
    end
  end

  assign perf_busy_cycles_o = perf_busy_q;
  assign perf_jobs_o        = perf_jobs_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sfu_job_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sfu_job_scheduler: directed job table plus reset sequence against a small SFU model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sfu_job_scheduler;

  localparam int NREQ = 2;
  localparam int DW   = 128;

  logic                 clk_i;
  logic                 rst_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [32*NREQ-1:0]   req_csr_i;
  logic [NREQ-1:0]      req_in_valid_i;
  logic [NREQ-1:0]      req_in_ready_o;
  logic [DW*NREQ-1:0]   req_in_bits_i;
  logic [NREQ-1:0]      req_out_valid_o;
  logic [NREQ-1:0]      req_out_ready_i;
  logic [DW-1:0]        req_out_bits_o;
  logic [NREQ-1:0]      req_done_o;
  logic [NREQ-1:0]      req_err_o;
  logic [31:0]          sfu_csr_o;
  logic                 sfu_start_o;
  logic                 sfu_busy_i;
  logic                 sfu_in_valid_o;
  logic                 sfu_in_ready_i;
  logic [DW-1:0]        sfu_in_bits_o;
  logic                 sfu_out_valid_i;
  logic                 sfu_out_ready_o;
  logic [DW-1:0]        sfu_out_bits_i;

  int n_cmp = 0;
  int n_bad = 0;

  sfu_job_scheduler #(
    .NUM_REQ (NREQ),
    .DataWidth (DW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_csr_i       (req_csr_i),
    .req_in_valid_i  (req_in_valid_i),
    .req_in_ready_o  (req_in_ready_o),
    .req_in_bits_i   (req_in_bits_i),
    .req_out_valid_o (req_out_valid_o),
    .req_out_ready_i (req_out_ready_i),
    .req_out_bits_o  (req_out_bits_o),
    .req_done_o      (req_done_o),
    .req_err_o       (req_err_o),
    .sfu_csr_o       (sfu_csr_o),
    .sfu_start_o     (sfu_start_o),
    .sfu_busy_i      (sfu_busy_i),
    .sfu_in_valid_o  (sfu_in_valid_o),
    .sfu_in_ready_i  (sfu_in_ready_i),
    .sfu_in_bits_o   (sfu_in_bits_o),
    .sfu_out_valid_i (sfu_out_valid_i),
    .sfu_out_ready_o (sfu_out_ready_o),
    .sfu_out_bits_i  (sfu_out_bits_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic [1:0] mask;
    int         win;
    int         opn;
    bit         busy;
    int         drop;
    bit         err;
    bit         start;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] in_pat(input int r, input int k);
    return {16'hC0DE, 16'(r), 32'(k), 32'(k * 7 + 3), 32'h5A5A_5A5A};
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({req_ready_o, req_in_ready_o, req_out_valid_o, req_done_o, req_err_o,
                sfu_start_o, sfu_in_valid_o, sfu_out_ready_o, sfu_csr_o});
  endfunction

  task automatic idle_inputs();
    req_valid_i     = '0;
    req_csr_i       = '0;
    req_in_valid_i  = '0;
    req_in_bits_i   = '0;
    req_out_ready_i = '0;
    sfu_busy_i      = 1'b0;
    sfu_in_ready_i  = 1'b0;
    sfu_out_valid_i = 1'b0;
    sfu_out_bits_i  = '0;
  endtask

  // One job from request to done, with the SFU modelled cycle by cycle.
  task automatic run_job(input logic [1:0] mask, input int win, input int opn, input bit busy_rises,
                         input int drop_at, input bit exp_err, input bit exp_start,
                         input int rst_at, input string nm);
    logic [31:0] csr;
    logic [1:0]  winmask;
    logic [1:0]  gnt_v, done_v, err_v;
    logic [31:0] csr_at_start;
    int cyc, grant_c, start_c, done_c, starts, in_hs, out_left, out_idx;
    int extra_rdy, loser_rdy, bits_bad, outv_bad, exp_beats;
    bit busy_on, done_seen, do_rst;
    csr = {6'b010000, 6'(opn), 20'h0};
    winmask = 2'b01 << win;
    gnt_v = '0; done_v = '0; err_v = '0; csr_at_start = '0;
    cyc = 0; grant_c = -1; start_c = -1; done_c = -1; starts = 0; in_hs = 0;
    out_left = 0; out_idx = 0; extra_rdy = 0; loser_rdy = 0; bits_bad = 0; outv_bad = 0;
    busy_on = 1'b0; done_seen = 1'b0; do_rst = 1'b0;
    while (!done_seen && !do_rst && cyc < 300) begin
      @(posedge clk_i); #1;
      req_valid_i     = (grant_c < 0) ? mask : (mask & ~winmask);
      req_csr_i       = {csr, csr};
      req_in_valid_i  = mask;
      for (int r = 0; r < NREQ; r++) req_in_bits_i[r*DW +: DW] = in_pat(r, in_hs);
      sfu_busy_i      = busy_on;
      sfu_in_ready_i  = busy_on;
      sfu_out_valid_i = (out_left > 0);
      sfu_out_bits_i  = {4{32'(out_idx)}};
      req_out_ready_i = (out_idx == drop_at) ? 2'b00 : winmask;
      @(negedge clk_i);
      cyc++;
      if (req_ready_o != '0) begin
        if (grant_c < 0) begin
          grant_c = cyc;
          gnt_v   = req_ready_o;
        end else begin
          extra_rdy++;
        end
      end
      if ((req_in_ready_o & ~winmask) != '0) loser_rdy++;
      if (sfu_start_o) begin
        starts++;
        start_c      = cyc;
        csr_at_start = sfu_csr_o;
        if (busy_rises) busy_on = 1'b1;
      end
      if (sfu_in_valid_o && sfu_in_ready_i) begin
        if (sfu_in_bits_o !== in_pat(win, in_hs)) bits_bad++;
        in_hs++;
        if (in_hs == opn) out_left = opn;
        if (in_hs == rst_at) do_rst = 1'b1;
      end
      if (sfu_out_valid_i) begin
        if (req_out_valid_o !== winmask || req_out_bits_o !== sfu_out_bits_i ||
            sfu_out_ready_o !== req_out_ready_i[win]) outv_bad++;
        out_idx++;
        out_left--;
        if (out_left == 0) busy_on = 1'b0;
      end
      if (req_done_o != '0) begin
        done_seen = 1'b1;
        done_c    = cyc;
        done_v    = req_done_o;
        err_v     = req_err_o;
      end
    end
    chk({nm, "_grant"}, 64'(gnt_v), 64'(winmask));
    chk({nm, "_held_off"}, 64'(extra_rdy), 64'd0);
    chk({nm, "_starts"}, 64'(starts), 64'(exp_start));
    if (exp_start) begin
      chk({nm, "_start_lat"}, 64'(start_c - grant_c), 64'd1);
      chk({nm, "_csr"}, 64'(csr_at_start), 64'(csr));
    end
    if (do_rst) begin
      chk({nm, "_no_done"}, 64'(done_seen), 64'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      idle_inputs();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk({nm, "_outs_zero"}, outs_vec(), 64'd0);
      return;
    end
    exp_beats = (exp_start && busy_rises) ? opn : 0;
    chk({nm, "_done"}, 64'(done_v), 64'(winmask));
    chk({nm, "_err"}, 64'(err_v), exp_err ? 64'(winmask) : 64'd0);
    chk({nm, "_in_beats"}, 64'(in_hs), 64'(exp_beats));
    chk({nm, "_out_beats"}, 64'(out_idx), 64'(exp_beats));
    chk({nm, "_in_bits"}, 64'(bits_bad), 64'd0);
    chk({nm, "_out_path"}, 64'(outv_bad), 64'd0);
    chk({nm, "_loser_rdy"}, 64'(loser_rdy), 64'd0);
    if (!exp_start) chk({nm, "_bad_lat"}, 64'(done_c - grant_c), 64'd2);
    if (exp_start && !busy_rises) chk({nm, "_timeout_lat"}, 64'(done_c - start_c), 64'd17);
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    // mask, winner, op_num, busy rises, drop beat, err, start
    vecs[0] = '{2'b11, 0, 4,  1'b1, -1, 1'b0, 1'b1};  // single job, also round 1 of contention
    vecs[1] = '{2'b11, 1, 2,  1'b1, -1, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 0, 1,  1'b1, -1, 1'b0, 1'b1};
    vecs[3] = '{2'b10, 1, 0,  1'b1, -1, 1'b1, 1'b0};  // op_num 0 illegal
    vecs[4] = '{2'b01, 0, 4,  1'b0, -1, 1'b1, 1'b1};  // busy never rises
    vecs[5] = '{2'b01, 0, 2,  1'b1,  0, 1'b1, 1'b1};  // first output beat dropped
    vecs[6] = '{2'b10, 1, 32, 1'b1, -1, 1'b0, 1'b1};  // largest legal op_num
    vecs[7] = '{2'b01, 0, 33, 1'b1, -1, 1'b1, 1'b0};  // one past the limit
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_outs", outs_vec(), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].mask, vecs[i].win, vecs[i].opn, vecs[i].busy, vecs[i].drop,
              vecs[i].err, vecs[i].start, -1, $sformatf("v%0d", i));
    end

    run_job(2'b01, 0, 8, 1'b1, -1, 1'b0, 1'b1, 3, "rst_mid");
    run_job(2'b11, 0, 4, 1'b1, -1, 1'b0, 1'b1, -1, "post_rst");

    @(posedge clk_i); #1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
